// File: rtl/vxe_pipe_2_stage.sv
// Purpose: one valid/data register of the delay pipeline; data loads only on a valid beat.
// Latency: 1 cycle.
// Backpressure: none; the valid bit shifts on every clock.
//
// Ports:
//   clk, nrst            clock and asynchronous active-low reset
//   prev_vld, prev_data  beat offered by the previous stage (or the pipeline input)
//   vld, data            registered beat held by this stage
module vxe_pipe_2_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  prev_vld,
    input  logic [DATA_WIDTH-1:0] prev_data,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            vld <= prev_vld;
            // Bubbles leave the data register untouched to avoid needless toggling.
            if (prev_vld) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/vxe_pipe_2.sv
// Purpose: fixed-latency delay line for a valid-qualified word, with an in-flight indicator.
// Latency: NSTAGES cycles from input to output, one beat per cycle.
// Backpressure: none; beats always advance, gaps are preserved exactly.
//
// Ports:
//   clk, nrst        clock and asynchronous active-low reset
//   i_vld, i_data    input beat; i_data is ignored when i_vld is low
//   o_vld, o_data    output beat from the last stage; o_data holds the last delivered word
//   o_busy           high while any stage holds a valid beat (excludes the current input)
module vxe_pipe_2 #(
    parameter int DATA_WIDTH = 32,
    parameter int NSTAGES    = 5
) (
    input  logic                  clk,
    input  logic                  nrst,
    output logic                  o_busy,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld
);

    if (NSTAGES < 1) begin : g_bad_nstages
        $error("vxe_pipe_2: NSTAGES must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("vxe_pipe_2: DATA_WIDTH must be >= 1");
    end

    logic [NSTAGES-1:0]    v;
    logic [DATA_WIDTH-1:0] d [NSTAGES];

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            vxe_pipe_2_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .clk      (clk),
                .nrst     (nrst),
                .prev_vld (i_vld),
                .prev_data(i_data),
                .vld      (v[k]),
                .data     (d[k])
            );
        end else begin : g_next
            vxe_pipe_2_stage #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_stage (
                .clk      (clk),
                .nrst     (nrst),
                .prev_vld (v[k-1]),
                .prev_data(d[k-1]),
                .vld      (v[k]),
                .data     (d[k])
            );
        end
    end

    assign o_vld  = v[NSTAGES-1];
    assign o_data = d[NSTAGES-1];
    assign o_busy = |v;

endmodule

// File: tb/tb_vxe_pipe_2.sv
module tb_vxe_pipe_2;

    logic        clk;
    logic        nrst;
    logic        i_vld;
    logic [31:0] i_data;

    logic        o_vld_5, o_busy_5;
    logic [31:0] o_data_5;
    logic        o_vld_1, o_busy_1;
    logic [7:0]  o_data_1;
    logic        o_vld_8, o_busy_8;
    logic [7:0]  o_data_8;

    int n_checks = 0;
    int n_errors = 0;

    // Input history since the last reset release: entry s is the beat presented in cycle s.
    localparam int HMAX = 2048;
    bit          hv [HMAX];
    logic [31:0] hd [HMAX];
    int          hcnt = 0;

    vxe_pipe_2 #(.DATA_WIDTH(32), .NSTAGES(5)) u_dut (
        .clk(clk), .nrst(nrst), .o_busy(o_busy_5),
        .i_data(i_data), .i_vld(i_vld), .o_data(o_data_5), .o_vld(o_vld_5)
    );

    vxe_pipe_2 #(.DATA_WIDTH(8), .NSTAGES(1)) u_dut_n1 (
        .clk(clk), .nrst(nrst), .o_busy(o_busy_1),
        .i_data(i_data[7:0]), .i_vld(i_vld), .o_data(o_data_1), .o_vld(o_vld_1)
    );

    vxe_pipe_2 #(.DATA_WIDTH(8), .NSTAGES(8)) u_dut_n8 (
        .clk(clk), .nrst(nrst), .o_busy(o_busy_8),
        .i_data(i_data[7:0]), .i_vld(i_vld), .o_data(o_data_8), .o_vld(o_vld_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // A beat presented in cycle s is visible after n clock edges from then, i.e. at cycle s+n.
    function automatic logic exp_vld(input int n);
        return (hcnt - n >= 0) ? logic'(hv[hcnt-n]) : 1'b0;
    endfunction

    function automatic logic [31:0] exp_data(input int n);
        for (int s = hcnt - n; s >= 0; s--) begin
            if (hv[s]) return hd[s];
        end
        return 32'h0;
    endfunction

    function automatic logic exp_busy(input int n);
        for (int s = hcnt - 1; s >= 0 && s >= hcnt - n; s--) begin
            if (hv[s]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".n5.vld"},  {31'h0, o_vld_5},  {31'h0, exp_vld(5)});
        check({tag, ".n5.data"}, o_data_5,          exp_data(5));
        check({tag, ".n5.busy"}, {31'h0, o_busy_5}, {31'h0, exp_busy(5)});
        check({tag, ".n1.vld"},  {31'h0, o_vld_1},  {31'h0, exp_vld(1)});
        check({tag, ".n1.data"}, {24'h0, o_data_1}, exp_data(1) & 32'hFF);
        check({tag, ".n1.busy"}, {31'h0, o_busy_1}, {31'h0, exp_busy(1)});
        check({tag, ".n8.vld"},  {31'h0, o_vld_8},  {31'h0, exp_vld(8)});
        check({tag, ".n8.data"}, {24'h0, o_data_8}, exp_data(8) & 32'hFF);
        check({tag, ".n8.busy"}, {31'h0, o_busy_8}, {31'h0, exp_busy(8)});
    endtask

    // Present one beat for one cycle, clock it in, then check every DUT 1 time unit later.
    task automatic step(input string tag, input logic vld, input logic [31:0] data);
        i_vld  = vld;
        i_data = data;
        @(posedge clk);
        if (nrst && hcnt < HMAX) begin
            hv[hcnt] = vld;
            hd[hcnt] = data;
            hcnt++;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        nrst   = 1'b0;
        i_vld  = 1'b0;
        i_data = 32'h0;
        #2;

        // Reset held: all outputs stay zero regardless of input data.
        for (int c = 0; c < 10; c++) step("reset", 1'b0, $urandom);
        @(negedge clk);
        nrst = 1'b1;

        // Single beat: visible 5 cycles later, then o_data keeps the word.
        step("single", 1'b1, 32'hBEEF0001);
        for (int c = 0; c < 8; c++) step("single", 1'b0, $urandom);
        check("single.hold", o_data_5, 32'hBEEF0001);

        // Burst of six back-to-back beats.
        for (int k = 0; k < 6; k++) step("burst", 1'b1, 32'hBEEF0001 + k);
        for (int c = 0; c < 10; c++) step("burst", 1'b0, $urandom);
        check("burst.hold", o_data_5, 32'hBEEF0006);

        // Alternating valid/gap: gaps carry garbage data that must be ignored.
        for (int k = 0; k < 6; k++) begin
            step("alt", 1'b1, 32'hBEEF0001 + k);
            step("alt", 1'b0, $urandom);
        end
        for (int c = 0; c < 8; c++) step("alt", 1'b0, $urandom);
        check("alt.hold", o_data_5, 32'hBEEF0006);

        // Mid-flight reset: assert between edges with beats in flight.
        for (int k = 0; k < 3; k++) step("midrst.fill", 1'b1, 32'hCAFE0010 + k);
        i_vld = 1'b0;
        #2;
        nrst = 1'b0;
        hcnt = 0;
        #1;
        check("midrst.n5.vld",  {31'h0, o_vld_5},  32'h0);
        check("midrst.n5.busy", {31'h0, o_busy_5}, 32'h0);
        check("midrst.n5.data", o_data_5,          32'h0);
        check("midrst.n8.busy", {31'h0, o_busy_8}, 32'h0);
        check("midrst.n1.vld",  {31'h0, o_vld_1},  32'h0);
        step("midrst.hold", 1'b1, $urandom);
        step("midrst.hold", 1'b0, $urandom);
        @(negedge clk);
        nrst = 1'b1;
        for (int c = 0; c < 12; c++) step("midrst.drain", 1'b0, $urandom);

        // Random stream across all three configurations.
        for (int c = 0; c < 400; c++) begin
            step("rand", 1'($urandom_range(0, 1)), $urandom);
        end
        for (int c = 0; c < 10; c++) step("rand.drain", 1'b0, $urandom);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
